// File: rtl/interleaver_ctrl.sv
// interleaver_ctrl: sequences a ROWS x COLS symbol bank. A frame is written
// row-major from the valid/ready input, then read column-major to the
// valid/ready output. Optional feature macro: INTLV_FLUSH_EN adds a
// synchronous flush input that abandons the current frame.
module interleaver_ctrl #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int ADDR_W = $clog2(ROWS*COLS)
) (
  input  logic              clk,
  input  logic              reset,
`ifdef INTLV_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              bank_we,
  output logic [ADDR_W-1:0] bank_waddr,
  output logic [7:0]        bank_wdata,
  output logic [ADDR_W-1:0] bank_raddr,
  input  logic [7:0]        bank_rdata,
  output logic              frame_done
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam logic [ROW_W-1:0] R_LAST = ROW_W'(ROWS-1);
  localparam logic [COL_W-1:0] C_LAST = COL_W'(COLS-1);
  localparam logic [ROW_W-1:0] R_ONE  = ROW_W'(1);
  localparam logic [COL_W-1:0] C_ONE  = COL_W'(1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t            state, state_nx;
  logic [ROW_W-1:0]  r, r_nx;
  logic [COL_W-1:0]  c, c_nx;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] raddr_hold;
  logic              flush_act;

`ifdef INTLV_FLUSH_EN
  assign flush_act = flush;
`else
  assign flush_act = 1'b0;
`endif

  // Shared row/column counters map to one linear bank address
  assign addr       = ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  assign bank_waddr = addr;
  assign bank_wdata = in_data;
  assign out_data   = bank_rdata;

  // State, counters and the last drain read address (held through FILL)
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FILL;
      r          <= '0;
      c          <= '0;
      raddr_hold <= '0;
    end else begin
      state      <= state_nx;
      r          <= r_nx;
      c          <= c_nx;
      raddr_hold <= bank_raddr;
    end
  end

  // Handshakes, counter stepping (row-major fill, column-major drain), outputs
  always_comb begin
    state_nx   = state;
    r_nx       = r;
    c_nx       = c;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    bank_we    = 1'b0;
    frame_done = 1'b0;
    bank_raddr = raddr_hold;
    unique case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bank_we = 1'b1;
          if (c == C_LAST) begin
            c_nx = '0;
            if (r == R_LAST) begin
              r_nx     = '0;
              state_nx = DRAIN;
            end else begin
              r_nx = r + R_ONE;
            end
          end else begin
            c_nx = c + C_ONE;
          end
        end
      end
      DRAIN: begin
        out_valid  = 1'b1;
        bank_raddr = addr;
        if (out_ready) begin
          if (r == R_LAST) begin
            r_nx = '0;
            if (c == C_LAST) begin
              c_nx       = '0;
              frame_done = 1'b1;
              state_nx   = FILL;
            end else begin
              c_nx = c + C_ONE;
            end
          end else begin
            r_nx = r + R_ONE;
          end
        end
      end
      default: ;
    endcase
    // Flush overrides any handshake decided above in the same cycle
    if (flush_act) begin
      state_nx   = FILL;
      r_nx       = '0;
      c_nx       = '0;
      bank_we    = 1'b0;
      frame_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_interleaver_ctrl.sv
// Directed bench for interleaver_ctrl: a 4x4 and a 2x3 instance, each with
// its own behavioural bank. Inputs change on the falling edge; outputs are
// checked 1 time unit later, well before the next rising edge.
module tb_interleaver_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
`ifdef INTLV_FLUSH_EN
  logic flush = 1'b0;
`endif
  always #5 clk = ~clk;

  // 4x4 instance
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, out_valid, bank_we, frame_done;
  logic [7:0] out_data, bank_wdata, bank_rdata;
  logic [3:0] bank_waddr, bank_raddr;
  logic [7:0] bank [16];

  // 2x3 instance
  logic       in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic [7:0] in_data2 = '0;
  logic       in_ready2, out_valid2, bank_we2, frame_done2;
  logic [7:0] out_data2, bank_wdata2, bank_rdata2;
  logic [2:0] bank_waddr2, bank_raddr2;
  logic [7:0] bank2 [8];

  int asserts = 0;
  int fails = 0;

  int exp_sq [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
  int exp_ns [6]  = '{0, 3, 1, 4, 2, 5};

  interleaver_ctrl u_sq (
    .clk(clk), .reset(reset),
`ifdef INTLV_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .bank_we(bank_we), .bank_waddr(bank_waddr), .bank_wdata(bank_wdata),
    .bank_raddr(bank_raddr), .bank_rdata(bank_rdata), .frame_done(frame_done)
  );

  interleaver_ctrl #(.ROWS(2), .COLS(3)) u_ns (
    .clk(clk), .reset(reset),
`ifdef INTLV_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .bank_we(bank_we2), .bank_waddr(bank_waddr2), .bank_wdata(bank_wdata2),
    .bank_raddr(bank_raddr2), .bank_rdata(bank_rdata2), .frame_done(frame_done2)
  );

  // Behavioural banks: clocked write, combinational read
  always @(posedge clk) if (bank_we) bank[bank_waddr] <= bank_wdata;
  always @(posedge clk) if (bank_we2) bank2[bank_waddr2] <= bank_wdata2;
  assign bank_rdata  = bank[bank_raddr];
  assign bank_rdata2 = bank2[bank_raddr2];

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    asserts++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    asserts++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    asserts++; if (bank_we !== 1'b0) begin fails++; $display("FAIL reset_bank_we: got %b expected 0", bank_we); end
    asserts++; if (bank_waddr !== 4'd0) begin fails++; $display("FAIL reset_waddr: got %0d expected 0", bank_waddr); end
    asserts++; if (bank_raddr !== 4'd0) begin fails++; $display("FAIL reset_raddr: got %0d expected 0", bank_raddr); end
    asserts++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
  endtask

  // Writes base+0 .. base+15 back to back, checking addresses in order
  task automatic write_frame(input int base);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(base + i);
      #1;
      asserts++; if (bank_we !== 1'b1 || bank_waddr !== 4'(i)) begin
        fails++; $display("FAIL write_addr[%0d]: got we=%b addr=%0d expected we=1 addr=%0d", i, bank_we, bank_waddr, i);
      end
    end
  endtask

  // Drains a full frame with out_ready=1, in_valid held high throughout
  task automatic drain_frame(input int base);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
      #1;
      asserts++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || bank_we !== 1'b0) begin
        fails++; $display("FAIL drain_ctrl[%0d]: got valid=%b ready=%b we=%b expected 1 0 0", j, out_valid, in_ready, bank_we);
      end
      asserts++; if (out_data !== 8'(base + exp_sq[j])) begin
        fails++; $display("FAIL drain_data[%0d]: got %0d expected %0d", j, out_data, base + exp_sq[j]);
      end
      asserts++; if (frame_done !== (j == 15)) begin
        fails++; $display("FAIL drain_done[%0d]: got %b expected %b", j, frame_done, j == 15);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    asserts++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL after_drain: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic_order;
    write_frame(0);
    drain_frame(0);
  endtask

  task automatic test_backpressure_gaps;
    logic [7:0] gaps = 8'b1011_0110;
    int written = 0;
    for (int k = 0; k < 64 && written < 16; k++) begin
      @(negedge clk);
      in_valid = gaps[k % 8]; in_data = 8'(written); out_ready = 1'b1;
      #1;
      if (in_valid) begin
        asserts++; if (bank_we !== 1'b1 || bank_waddr !== 4'(written)) begin
          fails++; $display("FAIL gap_write[%0d]: got we=%b addr=%0d expected we=1 addr=%0d", written, bank_we, bank_waddr, written);
        end
        written++;
      end else begin
        asserts++; if (bank_we !== 1'b0) begin fails++; $display("FAIL gap_idle_we: got %b expected 0", bank_we); end
      end
    end
    asserts++; if (written != 16) begin fails++; $display("FAIL gap_count: got %0d expected 16", written); end
    for (int j = 0; j < 16; j++) begin
      if (j == 6) begin
        for (int h = 0; h < 5; h++) begin
          @(negedge clk);
          in_valid = 1'b0; out_ready = 1'b0;
          #1;
          asserts++; if (out_valid !== 1'b1 || bank_raddr !== 4'd9 || out_data !== 8'd9) begin
            fails++; $display("FAIL stall[%0d]: got valid=%b raddr=%0d data=%0d expected 1 9 9", h, out_valid, bank_raddr, out_data);
          end
        end
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      asserts++; if (bank_raddr !== 4'(exp_sq[j]) || out_data !== 8'(exp_sq[j])) begin
        fails++; $display("FAIL bp_drain[%0d]: got raddr=%0d data=%0d expected %0d", j, bank_raddr, out_data, exp_sq[j]);
      end
    end
    @(negedge clk);
    #1;
    asserts++; if (in_ready !== 1'b1 || bank_raddr !== 4'd15) begin
      fails++; $display("FAIL bp_end: got ready=%b raddr=%0d expected 1 15", in_ready, bank_raddr);
    end
  endtask

  task automatic test_nonsquare;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid2 = 1'b1; in_data2 = 8'(i); out_ready2 = 1'b1;
      #1;
      asserts++; if (bank_we2 !== 1'b1 || bank_waddr2 !== 3'(i)) begin
        fails++; $display("FAIL ns_write[%0d]: got we=%b addr=%0d expected we=1 addr=%0d", i, bank_we2, bank_waddr2, i);
      end
    end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      in_valid2 = 1'b0;
      #1;
      asserts++; if (out_valid2 !== 1'b1 || out_data2 !== 8'(exp_ns[j]) || frame_done2 !== (j == 5)) begin
        fails++; $display("FAIL ns_drain[%0d]: got valid=%b data=%0d done=%b expected 1 %0d %b", j, out_valid2, out_data2, frame_done2, exp_ns[j], j == 5);
      end
    end
    @(negedge clk);
    out_ready2 = 1'b0;
    #1;
    asserts++; if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin
      fails++; $display("FAIL ns_end: got ready=%b valid=%b expected 1 0", in_ready2, out_valid2);
    end
  endtask

  task automatic test_reset_mid_drain;
    write_frame(200);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
    end
    @(negedge clk);
    reset = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    asserts++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || bank_waddr !== 4'd0 || bank_raddr !== 4'd0) begin
      fails++; $display("FAIL mid_reset: got ready=%b valid=%b waddr=%0d raddr=%0d expected 1 0 0 0", in_ready, out_valid, bank_waddr, bank_raddr);
    end
    write_frame(100);
    drain_frame(100);
  endtask

`ifdef INTLV_FLUSH_EN
  task automatic test_flush;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(50 + i);
    end
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'd99;
    #1;
    asserts++; if (bank_we !== 1'b0 || frame_done !== 1'b0) begin
      fails++; $display("FAIL flush_cycle: got we=%b done=%b expected 0 0", bank_we, frame_done);
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    asserts++; if (bank_waddr !== 4'd0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL flush_after: got waddr=%0d ready=%b expected 0 1", bank_waddr, in_ready);
    end
    write_frame(60);
    drain_frame(60);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_order();
    test_backpressure_gaps();
    test_nonsquare();
    test_reset_mid_drain();
`ifdef INTLV_FLUSH_EN
    test_flush();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
